io_stage: RTL and testbench

Memory-response stage of the five-stage MIPS pipeline, between the execute stage and `wb_stage`. It holds one instruction, waits for the data-SRAM response when that instruction issued a load or store, and aligns and extends load data (including LWL/LWR merge with the old rt value). It drives `io_to_wb_bus` and a forwarding/stall bus back to decode. A flush from write-back kills the held instruction and discards any orphaned memory response.

---
 rtl/io_stage.sv | 174 +++++++++++++++++
 tb/tb_io_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_stage.sv
// Memory-response stage: holds one instruction, waits for the data-SRAM response,
// aligns/extends load data (incl. LWL/LWR merge) and feeds WB plus the decode bypass.
package cpu_core_params;
  localparam int CpuData = 32;
endpackage

package ex_stage_params;
  import cpu_core_params::*;
  typedef struct packed {
    logic               valid;
    logic [CpuData-1:0] program_count;
    logic               memory_request;
    logic [2:0]         load_op;
    logic [1:0]         address_low;
    logic [CpuData-1:0] alu_result;
    logic [CpuData-1:0] rt_value;
    logic               register_file_write_enabled;
    logic [4:0]         register_file_address;
    logic [4:0]         cp0_address_register;
    logic [2:0]         cp0_address_select;
    logic               move_to_cp0;
    logic               exception_valid;
    logic [4:0]         exception_code;
    logic               eret_flush;
    logic               in_delay_slot;
  } EXToIOData;
endpackage

package io_stage_params;
  import cpu_core_params::*;
  typedef struct packed {
    logic               valid;
    logic [CpuData-1:0] program_count;
    logic               register_file_write_enabled;
    logic [4:0]         register_file_address;
    logic [4:0]         cp0_address_register;
    logic [2:0]         cp0_address_select;
    logic               move_to_cp0;
    logic               exception_valid;
    logic [4:0]         exception_code;
    logic               eret_flush;
    logic               in_delay_slot;
    logic [CpuData-1:0] final_result;
    logic [3:0]         register_file_write_strobe;
  } IOToWBData;

  typedef struct packed {
    logic               valid;
    logic [4:0]         write_register;
    logic [3:0]         write_strobe;
    logic [CpuData-1:0] write_data;
    logic               data_pending;
  } IOToIDBackPassData;
endpackage

module io_stage
  import cpu_core_params::*, ex_stage_params::*, io_stage_params::*;
(
  input  logic              clock,
  input  logic              reset,
  input  EXToIOData         ex_to_io_bus,
  output logic              io_allow_in,
  input  logic              data_ram_data_ok,
  input  logic [CpuData-1:0] data_ram_read_data,
  input  logic              wb_allow_in,
  input  logic              flush,
  output IOToWBData         io_to_wb_bus,
  output IOToIDBackPassData io_to_id_back_pass_bus
);
  typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_WAIT, S_DONE} state_t;

  localparam logic [2:0] OP_LW = 3'd0, OP_LB = 3'd1, OP_LBU = 3'd2, OP_LH = 3'd3,
                         OP_LHU = 3'd4, OP_LWL = 3'd5, OP_LWR = 3'd6;

  state_t             state, state_n;
  logic               discard, discard_n;
  EXToIOData          ex_r;
  logic [CpuData-1:0] rdata_r;
  logic               mem_ok, ready_go, accept;

  // A response owed to a flushed instruction never reaches the held one.
  assign mem_ok      = data_ram_data_ok & ~discard;
  assign ready_go    = (state == S_HOLD) | (state == S_DONE) | ((state == S_WAIT) & mem_ok);
  assign io_allow_in = (state == S_EMPTY) | (ready_go & wb_allow_in);
  assign accept      = ex_to_io_bus.valid & io_allow_in & ~flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_EMPTY;
      discard <= 1'b0;
    end else begin
      state   <= state_n;
      discard <= discard_n;
    end
  end

  always_comb begin
    state_n   = state;
    discard_n = discard;
    if (data_ram_data_ok && discard) discard_n = 1'b0;
    if (flush) begin
      state_n = S_EMPTY;
      if (state == S_WAIT && !mem_ok) discard_n = 1'b1;
    end else if (accept) begin
      state_n = ex_to_io_bus.memory_request ? S_WAIT : S_HOLD;
    end else if (ready_go && wb_allow_in) begin
      state_n = S_EMPTY;
    end else if (state == S_WAIT && mem_ok) begin
      state_n = S_DONE;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) ex_r <= ex_to_io_bus;
    if (state == S_WAIT && mem_ok) rdata_r <= data_ram_read_data;
  end

  // Load alignment; response is passed straight through while in WAIT.
  logic [CpuData-1:0] ld, merge_d, merged, final_result;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [3:0]         merge_strb, strobe;
  logic [1:0]         n;

  assign n          = ex_r.address_low;
  assign ld         = (state == S_WAIT) ? data_ram_read_data : rdata_r;
  assign ld_byte    = ld[{n, 3'b000} +: 8];
  assign ld_half    = n[1] ? ld[31:16] : ld[15:0];
  assign merge_d    = (ex_r.load_op == OP_LWL) ? (ld << {~n, 3'b000}) : (ld >> {n, 3'b000});
  assign merge_strb = (ex_r.load_op == OP_LWL) ? (4'hF << ~n) : (4'hF >> n);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = merge_strb[i] ? merge_d[8*i +: 8] : ex_r.rt_value[8*i +: 8];
  end

  always_comb begin
    final_result = ex_r.alu_result;
    strobe       = 4'hF;
    case (ex_r.load_op)
      OP_LW:  final_result = ld;
      OP_LB:  final_result = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU: final_result = {24'd0, ld_byte};
      OP_LH:  final_result = {{16{ld_half[15]}}, ld_half};
      OP_LHU: final_result = {16'd0, ld_half};
      OP_LWL, OP_LWR: begin
        final_result = merged;
        strobe       = merge_strb;
      end
      default: ;
    endcase
  end

  always_comb begin
    io_to_wb_bus.valid                       = ready_go & (state != S_EMPTY) & ~flush;
    io_to_wb_bus.program_count               = ex_r.program_count;
    io_to_wb_bus.register_file_write_enabled = ex_r.register_file_write_enabled;
    io_to_wb_bus.register_file_address       = ex_r.register_file_address;
    io_to_wb_bus.cp0_address_register        = ex_r.cp0_address_register;
    io_to_wb_bus.cp0_address_select          = ex_r.cp0_address_select;
    io_to_wb_bus.move_to_cp0                 = ex_r.move_to_cp0;
    io_to_wb_bus.exception_valid             = ex_r.exception_valid;
    io_to_wb_bus.exception_code              = ex_r.exception_code;
    io_to_wb_bus.eret_flush                  = ex_r.eret_flush;
    io_to_wb_bus.in_delay_slot               = ex_r.in_delay_slot;
    io_to_wb_bus.final_result                = final_result;
    io_to_wb_bus.register_file_write_strobe  = strobe;

    io_to_id_back_pass_bus.valid          = (state != S_EMPTY) & ex_r.register_file_write_enabled;
    io_to_id_back_pass_bus.write_register = ex_r.register_file_address;
    io_to_id_back_pass_bus.write_strobe   = strobe;
    io_to_id_back_pass_bus.write_data     = final_result;
    io_to_id_back_pass_bus.data_pending   = (state == S_WAIT) & ~mem_ok;
  end
endmodule

// File: tb/tb_io_stage.sv
// Directed bench for io_stage: load alignment, WB stall, flush/discard and async reset.
module tb_io_stage;
  import ex_stage_params::*, io_stage_params::*;

  logic              clock = 1'b0;
  logic              reset;
  EXToIOData         ex;
  logic              io_allow_in;
  logic              data_ram_data_ok;
  logic [31:0]       data_ram_read_data;
  logic              wb_allow_in;
  logic              flush;
  IOToWBData         wb;
  IOToIDBackPassData bp;

  int checks = 0;
  int errors = 0;

  io_stage dut (
    .clock(clock), .reset(reset), .ex_to_io_bus(ex), .io_allow_in(io_allow_in),
    .data_ram_data_ok(data_ram_data_ok), .data_ram_read_data(data_ram_read_data),
    .wb_allow_in(wb_allow_in), .flush(flush), .io_to_wb_bus(wb),
    .io_to_id_back_pass_bus(bp)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic set_ex(input logic v, input logic mr, input logic [2:0] op,
                        input logic [1:0] n, input logic [31:0] alu, input logic [31:0] rt);
    ex = '0;
    ex.valid                       = v;
    ex.program_count               = 32'hBFC0_0100;
    ex.memory_request              = mr;
    ex.load_op                     = op;
    ex.address_low                 = n;
    ex.alu_result                  = alu;
    ex.rt_value                    = rt;
    ex.register_file_write_enabled = 1'b1;
    ex.register_file_address       = 5'd9;
  endtask

  // Accept a load, return the response one cycle later, check what WB sees.
  task automatic do_load(input string tag, input logic [2:0] op, input logic [1:0] n,
                         input logic [31:0] rt, input logic [31:0] d,
                         input logic [31:0] exp_res, input logic [3:0] exp_strb);
    @(negedge clock);
    set_ex(1'b1, 1'b1, op, n, 32'h0, rt);
    @(negedge clock);
    set_ex(1'b0, 1'b0, 3'd7, 2'd0, 32'h0, 32'h0);
    data_ram_data_ok   = 1'b1;
    data_ram_read_data = d;
    #1;
    chk({tag, "_vld"}, {31'd0, wb.valid}, 32'd1);
    chk({tag, "_res"}, wb.final_result, exp_res);
    chk({tag, "_strb"}, {28'd0, wb.register_file_write_strobe}, {28'd0, exp_strb});
    @(negedge clock);
    data_ram_data_ok = 1'b0;
  endtask

  typedef struct {
    string       tag;
    logic [2:0]  op;
    logic [1:0]  n;
    logic [31:0] res;
    logic [3:0]  strb;
  } vec_t;

  vec_t vecs[10] = '{
    '{"lb1",  3'd1, 2'd1, 32'hFFFF_FFAA, 4'hF},
    '{"lbu3", 3'd2, 2'd3, 32'h0000_0088, 4'hF},
    '{"lh2",  3'd3, 2'd2, 32'hFFFF_8899, 4'hF},
    '{"lhu0", 3'd4, 2'd0, 32'h0000_AABB, 4'hF},
    '{"lwl1", 3'd5, 2'd1, 32'hAABB_3344, 4'hC},
    '{"lwr1", 3'd6, 2'd1, 32'h1188_99AA, 4'h7},
    '{"lwl0", 3'd5, 2'd0, 32'hBB22_3344, 4'h8},
    '{"lwl3", 3'd5, 2'd3, 32'h8899_AABB, 4'hF},
    '{"lwr0", 3'd6, 2'd0, 32'h8899_AABB, 4'hF},
    '{"lwr3", 3'd6, 2'd3, 32'h1122_3388, 4'h1}
  };

  initial begin
    reset = 1'b0;
    set_ex(1'b0, 1'b0, 3'd7, 2'd0, 32'h0, 32'h0);
    data_ram_data_ok = 1'b0;
    data_ram_read_data = '0;
    wb_allow_in = 1'b1;
    flush = 1'b0;
    #12;
    chk("rst_allow", {31'd0, io_allow_in}, 32'd1);
    chk("rst_wbvld", {31'd0, wb.valid}, 32'd0);
    chk("rst_bpvld", {31'd0, bp.valid}, 32'd0);
    chk("rst_pend",  {31'd0, bp.data_pending}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // LW with data_ok two cycles after accept, then an ALU op
    @(negedge clock);
    set_ex(1'b1, 1'b1, 3'd0, 2'd0, 32'h0, 32'h0);
    @(negedge clock);
    set_ex(1'b0, 1'b0, 3'd7, 2'd0, 32'h0, 32'h0);
    #1;
    chk("lw_wait_vld",  {31'd0, wb.valid}, 32'd0);
    chk("lw_wait_pend", {31'd0, bp.data_pending}, 32'd1);
    chk("lw_wait_bp",   {31'd0, bp.valid}, 32'd1);
    chk("lw_wait_reg",  {27'd0, bp.write_register}, 32'd9);
    chk("lw_wait_allow", {31'd0, io_allow_in}, 32'd0);
    @(negedge clock);
    data_ram_data_ok = 1'b1;
    data_ram_read_data = 32'h8899_AABB;
    set_ex(1'b1, 1'b0, 3'd7, 2'd0, 32'h0000_1234, 32'h0);
    #1;
    chk("lw_vld",   {31'd0, wb.valid}, 32'd1);
    chk("lw_res",   wb.final_result, 32'h8899_AABB);
    chk("lw_strb",  {28'd0, wb.register_file_write_strobe}, 32'hF);
    chk("lw_allow", {31'd0, io_allow_in}, 32'd1);
    chk("lw_fwd",   bp.write_data, 32'h8899_AABB);
    @(negedge clock);
    data_ram_data_ok = 1'b0;
    set_ex(1'b0, 1'b0, 3'd7, 2'd0, 32'h0, 32'h0);
    #1;
    chk("alu_vld", {31'd0, wb.valid}, 32'd1);
    chk("alu_res", wb.final_result, 32'h0000_1234);
    @(negedge clock);
    chk("alu_gone", {31'd0, wb.valid}, 32'd0);

    foreach (vecs[i])
      do_load(vecs[i].tag, vecs[i].op, vecs[i].n, 32'h1122_3344, 32'h8899_AABB,
              vecs[i].res, vecs[i].strb);

    // WB stall: response arrives while WB is blocked
    @(negedge clock);
    set_ex(1'b1, 1'b1, 3'd0, 2'd0, 32'h0, 32'h0);
    @(negedge clock);
    set_ex(1'b0, 1'b0, 3'd7, 2'd0, 32'h0, 32'h0);
    wb_allow_in = 1'b0;
    data_ram_data_ok = 1'b1;
    data_ram_read_data = 32'hCAFE_F00D;
    #1;
    chk("stall_allow0", {31'd0, io_allow_in}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      data_ram_data_ok = 1'b0;
      data_ram_read_data = 32'h0BAD_0BAD;
      #1;
      chk("stall_vld",   {31'd0, wb.valid}, 32'd1);
      chk("stall_res",   wb.final_result, 32'hCAFE_F00D);
      chk("stall_allow", {31'd0, io_allow_in}, 32'd0);
    end
    @(negedge clock);
    wb_allow_in = 1'b1;
    #1;
    chk("stall_rel_vld", {31'd0, wb.valid}, 32'd1);
    chk("stall_rel_res", wb.final_result, 32'hCAFE_F00D);
    chk("stall_rel_allow", {31'd0, io_allow_in}, 32'd1);
    @(negedge clock);
    chk("stall_gone", {31'd0, wb.valid}, 32'd0);

    // Flush while waiting: stale response must be swallowed
    set_ex(1'b1, 1'b1, 3'd0, 2'd0, 32'h0, 32'h0);
    @(negedge clock);
    set_ex(1'b0, 1'b0, 3'd7, 2'd0, 32'h0, 32'h0);
    flush = 1'b1;
    #1;
    chk("fl_vld", {31'd0, wb.valid}, 32'd0);
    @(negedge clock);
    flush = 1'b0;
    set_ex(1'b1, 1'b1, 3'd0, 2'd0, 32'h0, 32'h0);
    #1;
    chk("fl_allow", {31'd0, io_allow_in}, 32'd1);
    @(negedge clock);
    set_ex(1'b0, 1'b0, 3'd7, 2'd0, 32'h0, 32'h0);
    data_ram_data_ok = 1'b1;
    data_ram_read_data = 32'h0000_DEAD;
    #1;
    chk("fl_stale_vld", {31'd0, wb.valid}, 32'd0);
    @(negedge clock);
    data_ram_read_data = 32'h0000_0005;
    #1;
    chk("fl_new_vld", {31'd0, wb.valid}, 32'd1);
    chk("fl_new_res", wb.final_result, 32'h0000_0005);
    @(negedge clock);
    data_ram_data_ok = 1'b0;

    // Flush beats a simultaneous accept
    set_ex(1'b1, 1'b0, 3'd7, 2'd0, 32'h0000_0077, 32'h0);
    @(negedge clock);
    flush = 1'b1;
    #1;
    chk("flp_vld", {31'd0, wb.valid}, 32'd0);
    @(negedge clock);
    flush = 1'b0;
    set_ex(1'b0, 1'b0, 3'd7, 2'd0, 32'h0, 32'h0);
    #1;
    chk("flp_noacc", {31'd0, wb.valid}, 32'd0);
    chk("flp_bp",    {31'd0, bp.valid}, 32'd0);

    // Async reset mid-WAIT, with discard armed beforehand
    @(negedge clock);
    set_ex(1'b1, 1'b1, 3'd0, 2'd0, 32'h0, 32'h0);
    @(negedge clock);
    set_ex(1'b0, 1'b0, 3'd7, 2'd0, 32'h0, 32'h0);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    set_ex(1'b1, 1'b1, 3'd0, 2'd0, 32'h0, 32'h0);
    @(negedge clock);
    set_ex(1'b0, 1'b0, 3'd7, 2'd0, 32'h0, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_allow", {31'd0, io_allow_in}, 32'd1);
    chk("ar_wbvld", {31'd0, wb.valid}, 32'd0);
    chk("ar_bpvld", {31'd0, bp.valid}, 32'd0);
    chk("ar_pend",  {31'd0, bp.data_pending}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      chk("ar_post_vld", {31'd0, wb.valid}, 32'd0);
    end
    do_load("ar_lw", 3'd0, 2'd0, 32'h0, 32'h0000_0042, 32'h0000_0042, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
